// File: rtl/mux_8x1_serializer.sv
// mux_8x1_serializer: captures an 8-bit word, drives it onto the mux data
// inputs A..H and steps the mux select 000..111. Each select change is
// followed by DWELL settle cycles, then a Bit_Valid strobe that the consumer
// acknowledges with Out_Ready.
module mux_8x1_serializer #(
  parameter int unsigned DWELL = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Load_Valid,
  input  logic [7:0] Data,
  output logic       Load_Ready,
  input  logic       Out_Ready,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       H,
  output logic       Sel2,
  output logic       Sel1,
  output logic       Sel0,
  output logic       Bit_Valid,
  output logic       Last
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Counter reload: it is checked for zero before decrementing, so loading
  // DWELL-1 yields exactly DWELL low cycles before the strobe.
  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] word_q, word_d;
  logic [2:0] sel_q, sel_d;

  // Next-state logic: load in IDLE, settle countdown, per-bit handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (Load_Valid) begin
          word_d  = Data;
          sel_d   = '0;
          cnt_d   = RELOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PRESENT: begin
        if (Out_Ready) begin
          if (sel_q == 3'd7) begin
            sel_d   = '0;
            state_d = IDLE;
          end else begin
            sel_d   = sel_q + 3'd1;
            cnt_d   = RELOAD;
            state_d = SETTLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous, highest-priority reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

  assign Load_Ready = (state_q == IDLE);
  assign Bit_Valid  = (state_q == PRESENT);
  assign Last       = Bit_Valid && (sel_q == 3'd7);
  assign {H, G, F, E, D, C, B, A} = word_q;
  assign {Sel2, Sel1, Sel0}       = sel_q;

endmodule

// File: doc/mux_8x1_serializer.md
# mux_8x1_serializer

Upstream driver for the 8:1 mux stage. The block accepts an 8-bit word through a valid/ready load handshake, holds it on the mux data inputs A..H, and steps the select lines Sel2..Sel0 from 000 to 111. After each select change it waits a programmable settle time, then presents a bit strobe that the consumer acknowledges. The mux output O is therefore a word serialized A-first, with a handshake per bit.

## Interface
- DWELL, 2: settle cycles after each select change before Bit_Valid may assert; legal range 1..255.
- Clk  input  1  single clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Load_Valid  input  1  producer offers a word on Data.
- Data  input  8  word to serialize; Data[0] maps to A, Data[7] maps to H.
- Load_Ready  output  1  block can accept a word.
- Out_Ready  input  1  consumer accepts the current mux bit.
- A, B, C, D, E, F, G, H  output  1 each  registered word bits driven to the mux data inputs.
- Sel2, Sel1, Sel0  output  1 each  registered mux select; Sel2 is the MSB.
- Bit_Valid  output  1  mux output O is settled for the current select.
- Last  output  1  current bit is the eighth one (select 111); qualified by Bit_Valid.

## Operation
- States:
  - IDLE: Load_Ready=1, Bit_Valid=0, {Sel2,Sel1,Sel0}=000.
  - SETTLE: the settle counter is running.
  - PRESENT: Bit_Valid=1, waiting for Out_Ready.
- Load: in IDLE, Load_Valid=1 at an edge does the following:
  - captures Data into A..H;
  - sets select to 000;
  - loads the settle counter with DWELL-1;
  - moves to SETTLE.
- SETTLE: the counter decrements each cycle. When the counter reads 0 at an edge, the state moves to PRESENT.
- PRESENT, Out_Ready=1 at an edge (bit transfer):
  - select below 111: select increments by 1, the counter reloads DWELL-1, and the state returns to SETTLE.
  - select at 111: the state goes to IDLE and select returns to 000.
- Out_Ready=0 in PRESENT: all outputs hold; no timeout.
- Last = Bit_Valid and select==111.
- Out_Ready is ignored outside PRESENT. Load_Valid is ignored outside IDLE; a word offered while busy is neither captured nor lost, and the producer keeps holding it.
- A..H are stable for the whole word. After completion they keep the last word until the next load or reset.
- Select only ever counts 000→111 by +1. No wrap occurs inside a word: after 111 the block always returns to IDLE.
- Settle counter is 8 bits wide, unsigned, and never underflows (it is reloaded before reuse).

## Timing
- Reset: on an edge with Rst=1, state goes to IDLE and the settle counter to 0. Output values during reset:
  - A..H=0;
  - Sel=000;
  - Bit_Valid=0, Last=0;
  - Load_Ready=1 from the first edge after Rst deasserts (it also reads 1 during reset, since the state is IDLE).
- Reset has priority over every other event. A reset mid-word abandons the word; no further Bit_Valid is produced for it.
- Load accepted at edge N: Sel=000 from edge N, and Bit_Valid rises at edge N+DWELL.
- Bit transfer at edge M (not last): the new select appears at edge M and Bit_Valid is low from edge M through M+DWELL-1. The gap of DWELL low cycles is mandatory even when Out_Ready is held at 1.
- Minimum word time with Out_Ready tied to 1: 8×DWELL + 8 cycles from load to the return to IDLE. The next load is possible at the edge after Load_Ready rises.
- Last transfer at edge M: Load_Ready=1 and Sel=000 from edge M.
- DWELL=1: Bit_Valid alternates high and low each cycle under continuous Out_Ready.

## Test plan
- Reset: hold Rst=1 for 2 cycles with Load_Valid=1 and Data=8'hFF → A..H=0, Sel=000, Bit_Valid=0, Load_Ready=1, nothing captured.
- Basic word, DWELL=2, Data=8'b1010_1010, Out_Ready=1 → mux O sequence 0,1,0,1,0,1,0,1 on Sel 0..7, Bit_Valid high 1 of every 3 cycles, Last only at Sel=111, Load_Ready returns 24 cycles after the load.
- Backpressure: Out_Ready=0 for 5 cycles at Sel=011 → Sel, Bit_Valid=1 and A..H all hold. Release → Sel=100 on the next edge and Bit_Valid low for DWELL cycles.
- Load while busy: Load_Valid=1 with Data=8'h3C mid-word → A..H unchanged and Load_Ready=0. After the word completes, 8'h3C is captured on the first IDLE edge.
- Reset mid-word at Sel=101 → next edge gives Sel=000, Bit_Valid=0, A..H=0, Load_Ready=1. A following load of 8'h01 serializes correctly, with O=1 only at Sel=000.
- DWELL=1 back-to-back: two words 8'h0F then 8'hF0, Out_Ready=1 → 16 Bit_Valid pulses with no missed or duplicated select value.
